// File: rtl/ascii_digit_packer_pkg.sv
// Shared constants and types for the ASCII digit packer.
// The ASCII codes and the emitter state encoding used by the packer and its decoder.
package ascii_digit_packer_pkg;

  localparam logic [3:0] BlankCode  = 4'hF;

  localparam logic [7:0] AsciiZero  = 8'h30;
  localparam logic [7:0] AsciiNine  = 8'h39;
  localparam logic [7:0] AsciiSpace = 8'h20;
  localparam logic [7:0] AsciiClrU  = 8'h43;
  localparam logic [7:0] AsciiClrL  = 8'h63;
  localparam logic [7:0] AsciiEsc   = 8'h1B;

  typedef enum logic [2:0] {
    StIdle,
    StRd0,
    StRd1,
    StRd2,
    StTail,
    StGap
  } emit_state_e;

endpackage

// File: rtl/ascii_to_dec.sv
// Combinational ASCII byte classifier: digits and space become 4-bit codes, and the
// clear characters are flagged. Any other byte produces neither flag.
module ascii_to_dec
  import ascii_digit_packer_pkg::*;
#(
  parameter logic [3:0] Blank = BlankCode
) (
  input  logic [7:0] data_i,
  output logic       is_digit_o,
  output logic       is_clear_o,
  output logic [3:0] code_o
);

  always_comb begin
    is_digit_o = 1'b0;
    is_clear_o = 1'b0;
    code_o     = Blank;
    if (data_i >= AsciiZero && data_i <= AsciiNine) begin
      // 0x30..0x39: the low nibble is already the digit value
      is_digit_o = 1'b1;
      code_o     = data_i[3:0];
    end else if (data_i == AsciiSpace) begin
      is_digit_o = 1'b1;
    end else if (data_i == AsciiClrU || data_i == AsciiClrL || data_i == AsciiEsc) begin
      is_clear_o = 1'b1;
    end
  end

endmodule

// File: rtl/ascii_digit_packer.sv
// Packs decoded ASCII digits into 3-digit frames and replays each frame as a fixed
// oRD/oDEC burst for the scroller; clear commands become a registered oCLEAN pulse.
module ascii_digit_packer
  import ascii_digit_packer_pkg::*;
#(
  // The emitter has one read state per slot, so only DIGITS == 3 is meaningful.
  parameter int unsigned DIGITS = 3,
  parameter logic [3:0]  BLANK  = BlankCode,
  parameter int unsigned GAP    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] iDATA,
  input  logic       iVALID,
  output logic       oREADY,
  output logic [3:0] oDEC,
  output logic       oRD,
  output logic       oCLEAN,
  output logic       oOVF
);

  localparam int unsigned GapW     = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GapW-1:0] GapLast = GapW'(GAP - 1);
  localparam logic [1:0] FillFull  = 2'(DIGITS);

  logic       is_digit;
  logic       is_clear;
  logic [3:0] code;

  ascii_to_dec #(
    .Blank (BLANK)
  ) u_dec (
    .data_i     (iDATA),
    .is_digit_o (is_digit),
    .is_clear_o (is_clear),
    .code_o     (code)
  );

  emit_state_e             state_q, state_d;
  logic [DIGITS-1:0][3:0]  buf_q, buf_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [1:0]              fill_q, fill_d;
  logic [GapW-1:0]         gap_cnt_q, gap_cnt_d;
  logic                    clr_pend_q, clr_pend_d;
  logic                    ovf_q, ovf_d;
  logic                    rd_q, rd_d;
  logic [3:0]              dec_q, dec_d;
  logic                    clean_q, clean_d;

  logic ready;
  logic meaningful;
  logic accept;
  logic drop;
  logic load;

  assign ready      = (fill_q != FillFull);
  assign meaningful = is_digit | is_clear;
  assign accept     = iVALID & ready & meaningful;
  assign drop       = iVALID & ~ready & meaningful;

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    shadow_d   = shadow_q;
    fill_d     = fill_q;
    gap_cnt_d  = gap_cnt_q;
    clr_pend_d = clr_pend_q;
    ovf_d      = ovf_q;

    // A pending clear takes the idle cycle; a waiting frame loads on the next one.
    clean_d = (state_q == StIdle) & clr_pend_q;
    load    = (state_q == StIdle) & ~clr_pend_q & (fill_q == FillFull);

    if (clean_d) begin
      clr_pend_d = 1'b0;
      ovf_d      = 1'b0;
    end

    if (load) begin
      shadow_d = buf_q;
      fill_d   = 2'd0;
    end

    // accept implies the buffer is not full, so it never collides with load
    if (accept) begin
      if (is_clear) begin
        fill_d     = 2'd0;
        clr_pend_d = 1'b1;
      end else begin
        buf_d[fill_q] = code;
        fill_d        = fill_q + 2'd1;
      end
    end

    if (drop) begin
      ovf_d = 1'b1;
    end

    unique case (state_q)
      StIdle: if (load) state_d = StRd0;
      StRd0:  state_d = StRd1;
      StRd1:  state_d = StRd2;
      StRd2:  state_d = StTail;
      StTail: begin
        state_d   = StGap;
        gap_cnt_d = '0;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Outputs are registered from the next state so they line up with state_q.
    rd_d = (state_d == StRd0) || (state_d == StRd1) || (state_d == StRd2);
    case (state_d)
      StRd1:   dec_d = shadow_d[0];
      StRd2:   dec_d = shadow_d[1];
      StTail:  dec_d = shadow_d[2];
      default: dec_d = BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      buf_q      <= '0;
      shadow_q   <= '0;
      fill_q     <= 2'd0;
      gap_cnt_q  <= '0;
      clr_pend_q <= 1'b0;
      ovf_q      <= 1'b0;
      rd_q       <= 1'b0;
      dec_q      <= BLANK;
      clean_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      shadow_q   <= shadow_d;
      fill_q     <= fill_d;
      gap_cnt_q  <= gap_cnt_d;
      clr_pend_q <= clr_pend_d;
      ovf_q      <= ovf_d;
      rd_q       <= rd_d;
      dec_q      <= dec_d;
      clean_q    <= clean_d;
    end
  end

  assign oREADY = ready;
  assign oDEC   = dec_q;
  assign oRD    = rd_q;
  assign oCLEAN = clean_q;
  assign oOVF   = ovf_q;

endmodule

// File: tb/tb_ascii_digit_packer.sv
// Self-checking bench for ascii_digit_packer: vector table, directed corner sequences and
// random traffic checked by a burst monitor against a frame-level reference model.
module tb_ascii_digit_packer;

  localparam int GAP = 2;

  logic       clk;
  logic       rst;
  logic [7:0] iDATA;
  logic       iVALID;
  logic       oREADY;
  logic [3:0] oDEC;
  logic       oRD;
  logic       oCLEAN;
  logic       oOVF;

  ascii_digit_packer #(
    .DIGITS (3),
    .BLANK  (4'hF),
    .GAP    (GAP)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .iDATA  (iDATA),
    .iVALID (iVALID),
    .oREADY (oREADY),
    .oDEC   (oDEC),
    .oRD    (oRD),
    .oCLEAN (oCLEAN),
    .oOVF   (oOVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Expected frames {s0,s1,s2}, oldest first
  logic [11:0] exp_q[$];

  // Monitor state
  bit         in_burst    = 0;
  bit         seen_burst  = 0;
  int         rd_len      = 0;
  int         low_run     = 0;
  int         bursts_done = 0;
  int         clean_cnt   = 0;
  logic [3:0] cap0, cap1, cap2;

  typedef struct {
    logic [39:0] bytes_in;
    logic [11:0] exp_frame;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit need_ready);
    int guard = 0;
    @(negedge clk);
    if (need_ready) begin
      while (!oREADY && guard < 60) begin
        @(negedge clk);
        guard++;
      end
      if (!oREADY) check("ready_timeout", {31'd0, oREADY}, 32'd1);
    end
    iDATA  = b;
    iVALID = 1'b1;
    @(posedge clk);
    #1;
    iVALID = 1'b0;
    iDATA  = 8'h00;
  endtask

  task automatic wait_drain();
    int g = 0;
    while ((exp_q.size() != 0 || in_burst) && g < 300) begin
      @(negedge clk);
      g++;
    end
    repeat (GAP + 4) @(negedge clk);
    check("drain", exp_q.size(), 0);
  endtask

  task automatic wait_rd_high();
    int g = 0;
    while (!oRD && g < 60) begin
      @(negedge clk);
      g++;
    end
    check("rd_rise_timeout", {31'd0, oRD}, 32'd1);
  endtask

  // Burst monitor: frame contents, burst length and inter-burst low time
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_burst   = 0;
        seen_burst = 0;
        rd_len     = 0;
        low_run    = 0;
      end else begin
        if (oCLEAN) clean_cnt++;
        if (oRD) begin
          if (!in_burst) begin
            in_burst = 1;
            rd_len   = 0;
            if (seen_burst) check("gap_low_cycles", {31'd0, low_run >= GAP}, 32'd1);
          end
          if (rd_len == 0) check("rd0_blank", {28'd0, oDEC}, 32'hF);
          else if (rd_len == 1) cap0 = oDEC;
          else if (rd_len == 2) cap1 = oDEC;
          rd_len++;
        end else begin
          if (in_burst) begin
            in_burst = 0;
            cap2     = oDEC;
            check("burst_len", rd_len, 3);
            if (exp_q.size() == 0) begin
              check("unexpected_burst", exp_q.size(), 1);
            end else begin
              check("frame", {20'd0, cap0, cap1, cap2}, {20'd0, exp_q.pop_front()});
            end
            seen_burst = 1;
            low_run    = 0;
            bursts_done++;
          end
          low_run++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[6];
    logic [3:0] lat_rd [6];
    logic [3:0] lat_dec[6];
    int         c0, b0, g;
    logic [3:0] model[$];
    logic [7:0] b;
    logic [39:0] bytes;

    vecs[0] = '{bytes_in: {"1", "2", "3", 8'h00, 8'h7F}, exp_frame: 12'h123};
    vecs[1] = '{bytes_in: {"9", " ", "8", "x", "~"},     exp_frame: 12'h9F8};
    vecs[2] = '{bytes_in: {"4", "x", 8'h0A, "5", "6"},   exp_frame: 12'h456};
    vecs[3] = '{bytes_in: {"/", "0", ":", "9", " "},     exp_frame: 12'h09F};
    vecs[4] = '{bytes_in: {"@", "7", "A", "7", "7"},     exp_frame: 12'h777};
    vecs[5] = '{bytes_in: {" ", " ", " ", "B", "Z"},     exp_frame: 12'hFFF};

    lat_rd  = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0};
    lat_dec = '{4'hF, 4'hF, 4'h1, 4'h2, 4'h3, 4'hF};

    iDATA  = 8'h00;
    iVALID = 1'b0;
    rst    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_ready", {31'd0, oREADY}, 32'd1);
    check("reset_rd",    {31'd0, oRD},    32'd0);
    check("reset_dec",   {28'd0, oDEC},   32'hF);
    check("reset_clean", {31'd0, oCLEAN}, 32'd0);
    check("reset_ovf",   {31'd0, oOVF},   32'd0);
    rst = 1'b1;

    // "123": exact cycle placement of the burst after the completing byte
    exp_q.push_back(12'h123);
    send_byte("1", 1);
    send_byte("2", 1);
    send_byte("3", 1);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check($sformatf("lat_rd_a+%0d", k + 1),  {31'd0, oRD},  {28'd0, lat_rd[k]});
      check($sformatf("lat_dec_a+%0d", k + 1), {28'd0, oDEC}, {28'd0, lat_dec[k]});
    end
    wait_drain();

    // Vector table: byte strings with junk mixed in, one expected frame each
    for (int v = 0; v < 6; v++) begin
      exp_q.push_back(vecs[v].exp_frame);
      bytes = vecs[v].bytes_in;
      for (int i = 4; i >= 0; i--) send_byte(bytes[i*8 +: 8], 1);
      wait_drain();
      check($sformatf("vec%0d_ovf", v), {31'd0, oOVF}, 32'd0);
    end

    // Back-to-back frames: second one stalls, a forced byte overflows
    exp_q.push_back(12'h123);
    exp_q.push_back(12'h456);
    send_byte("1", 1);
    send_byte("2", 1);
    send_byte("3", 1);
    send_byte("4", 1);
    send_byte("5", 1);
    send_byte("6", 1);
    @(negedge clk);
    check("stall_ready_low", {31'd0, oREADY}, 32'd0);
    send_byte("7", 0);
    @(negedge clk);
    check("ovf_set", {31'd0, oOVF}, 32'd1);
    wait_drain();
    check("ovf_sticky", {31'd0, oOVF}, 32'd1);

    // "12C": flush, one clean pulse, no burst, overflow cleared
    c0 = clean_cnt;
    b0 = bursts_done;
    send_byte("1", 1);
    send_byte("2", 1);
    send_byte("C", 1);
    repeat (6) @(negedge clk);
    check("clr_pulse_count", clean_cnt - c0, 1);
    check("clr_no_burst", bursts_done - b0, 0);
    check("clr_ovf_cleared", {31'd0, oOVF}, 32'd0);
    check("clr_ready", {31'd0, oREADY}, 32'd1);

    // Lower-case 'c' and ESC are clears too
    c0 = clean_cnt;
    send_byte("9", 1);
    send_byte("c", 1);
    repeat (4) @(negedge clk);
    send_byte(8'h1B, 1);
    repeat (4) @(negedge clk);
    check("clr_lower_esc_count", clean_cnt - c0, 2);

    // Clear during a burst: burst drains first, then the pulse
    exp_q.push_back(12'h456);
    b0 = bursts_done;
    c0 = clean_cnt;
    send_byte("4", 1);
    send_byte("5", 1);
    send_byte("6", 1);
    wait_rd_high();
    send_byte("C", 1);
    g = 0;
    while (clean_cnt == c0 && g < 40) begin
      @(negedge clk);
      g++;
    end
    check("clr_burst_pulse", clean_cnt - c0, 1);
    check("clr_after_burst", bursts_done - b0, 1);
    wait_drain();

    // Reset asserted in RD1
    exp_q.push_back(12'h555);
    send_byte("5", 1);
    send_byte("5", 1);
    send_byte("5", 1);
    wait_rd_high();
    @(negedge clk);
    check("rd1_dec", {28'd0, oDEC}, 32'h5);
    #1;
    rst = 1'b0;
    exp_q.delete();
    #1;
    check("rst_mid_rd",    {31'd0, oRD},    32'd0);
    check("rst_mid_dec",   {28'd0, oDEC},   32'hF);
    check("rst_mid_ready", {31'd0, oREADY}, 32'd1);
    @(posedge clk);
    #1;
    check("rst_edge_rd", {31'd0, oRD}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    exp_q.push_back(12'h777);
    send_byte("7", 1);
    send_byte("7", 1);
    send_byte("7", 1);
    wait_drain();

    // Random traffic against the frame model
    c0 = clean_cnt;
    model.delete();
    for (int n = 0; n < 240; n++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3, 4, 5: b = 8'h30 + 8'($urandom_range(0, 9));
        6:                b = 8'h20;
        default: begin
          b = 8'($urandom);
          while ((b >= 8'h30 && b <= 8'h39) || b == 8'h20 || b == 8'h43 || b == 8'h63 ||
                 b == 8'h1B) b = 8'($urandom);
        end
      endcase
      if (b >= 8'h30 && b <= 8'h39) model.push_back(b[3:0]);
      else if (b == 8'h20) model.push_back(4'hF);
      if (model.size() == 3) begin
        exp_q.push_back({model[0], model[1], model[2]});
        model.delete();
      end
      send_byte(b, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain();
    check("rand_ovf", {31'd0, oOVF}, 32'd0);
    check("rand_no_clean", clean_cnt - c0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
